counter_monitor: RTL
====================

// Module: counter_monitor
// PURPOSE
//  Consumer/checker on the counter output interface (en, count). Tracks the value the counter
//  must hold each cycle and flags any deviation, counts errors, reports wrap-around.
//  Sits beside the counter in silicon as a built-in self-check. Status goes to the debug/status
//  registers.
// PARAMETERS
//  WIDTH      4   width of monitored count bus
//  ERR_LIMIT  3   consecutive mismatches that force FAULT (1..15)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst_n     in   1      reset; synchronous, active-low
//  en        in   1      counter enable, same signal driving the counter
//  count     in   WIDTH  counter output being monitored
//  clr_err   in   1      clear err_cnt/fault, resync tracking
//  locked    out  1      monitor has history and is checking
//  mismatch  out  1      1-cycle pulse: count differed from expected
//  wrap      out  1      1-cycle pulse: count went all-ones -> 0 with en
//  err_cnt   out  8      total mismatches since reset/clr_err, saturates at 255
//  fault     out  1      sticky: ERR_LIMIT consecutive mismatches seen
// BEHAVIOUR
//  - All state changes on rising clk. rst_n low at an edge: state=SYNC, locked=0, mismatch=0,
//    wrap=0, err_cnt=0, fault=0, history regs=0. Reset mid-operation discards all history.
//  - History: cnt_q<=count, en_q<=en every cycle in every state.
//  - Expected = (cnt_q + en_q) mod 2^WIDTH; wraps all-ones -> 0, no carry out.
//  - FSM:
//    SYNC  : capture history only; next cycle -> TRACK, locked=1 from the cycle TRACK is entered.
//    TRACK : compare count vs expected each cycle. Mismatch -> mismatch=1 next cycle,
//            err_cnt+1 (sat 255), consec+1. Match -> consec=0. consec reaching ERR_LIMIT -> FAULT.
//    FAULT : fault=1, locked=0, no comparisons, err_cnt frozen; exit only via clr_err or reset.
//  - Latency: offending count sampled at edge N -> mismatch high for cycle after edge N.
//  - wrap=1 for one cycle when in TRACK, en_q=1, cnt_q=all-ones, count=0 (valid wrap only;
//    a mismatch to 0 does not assert wrap).
//  - clr_err (any state): err_cnt=0, consec=0, fault=0, mismatch=0, -> SYNC, locked=0.
//    clr_err and a mismatch on same edge: clear wins, mismatch not counted.
//  - en held low: expected=cnt_q; any change in count is a mismatch.
//  - After 255, err_cnt holds; mismatch pulses continue.
// CONFIGURATION
//  COUNT_MON_WRAP_CNT_EN defined: extra port wrap_cnt out 16, increments on each wrap pulse,
//    wraps 0xFFFF->0, cleared by reset and clr_err.
//  Undefined: no wrap_cnt port or register; all other behaviour identical.
// TESTING (WIDTH=4, ERR_LIMIT=3)
//  1 rst_n=0 2 cycles, release, en=0, count=0 -> locked=1 from cycle 2, mismatch never, err_cnt=0.
//  2 en=1, count 0,1..15,0,1 -> no mismatch; wrap=1 exactly one cycle after 15->0; wrap_cnt=1 if EN.
//  3 in TRACK force count 5->7 with en=1 once -> mismatch 1 cycle, err_cnt=1, fault=0.
//  4 three consecutive bad counts -> err_cnt=3, fault=1, locked=0; further bad counts: err_cnt stays 3.
//  5 in FAULT pulse clr_err -> err_cnt=0, fault=0, SYNC then locked=1 next cycle.
//  6 rst_n=0 for one edge mid-count at count=9 -> all outputs reset, resync, no spurious mismatch.

Source files
------------

// File: rtl/counter_monitor.sv
// Built-in self-check beside a free-running counter: predicts the next count from the sampled history,
// flags deviations, counts errors and reports wrap-around. Define COUNT_MON_WRAP_CNT_EN to add the wrap_cnt port.
module counter_monitor #(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap,
    output logic [7:0]       err_cnt,
    output logic             fault
`ifdef COUNT_MON_WRAP_CNT_EN
    ,
    output logic [15:0]      wrap_cnt
`endif
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [3:0]       LIMIT_VAL = 4'(ERR_LIMIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             mismatch_q, mismatch_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [3:0]       consec_q, consec_d;
    logic             fault_q, fault_d;

    logic [WIDTH-1:0] expected;
    logic             differs;
    logic [3:0]       consec_inc;

    always_comb begin
        expected   = cnt_q + {{(WIDTH-1){1'b0}}, en_q};
        differs    = (count != expected);
        consec_inc = consec_q + 4'd1;

        state_d    = state_q;
        cnt_d      = count;
        en_d       = en;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        consec_d   = consec_q;
        fault_d    = fault_q;

        // A clear on the same edge as a bad count discards that mismatch.
        if (clr_err) begin
            state_d   = SYNC;
            err_cnt_d = 8'd0;
            consec_d  = 4'd0;
            fault_d   = 1'b0;
        end else begin
            case (state_q)
                SYNC: state_d = TRACK;
                TRACK: begin
                    if (differs) begin
                        mismatch_d = 1'b1;
                        consec_d   = consec_inc;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (consec_inc >= LIMIT_VAL) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end
                    end else begin
                        consec_d = 4'd0;
                        wrap_d   = en_q && (cnt_q == ALL_ONES) && (count == '0);
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= 8'd0;
            consec_q   <= 4'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
            consec_q   <= consec_d;
            fault_q    <= fault_d;
        end
    end

    assign locked   = (state_q == TRACK);
    assign mismatch = mismatch_q;
    assign wrap     = wrap_q;
    assign err_cnt  = err_cnt_q;
    assign fault    = fault_q;

`ifdef COUNT_MON_WRAP_CNT_EN
    logic [15:0] wrap_cnt_q, wrap_cnt_d;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clr_err) begin
            wrap_cnt_d = 16'd0;
        end else if (wrap_d) begin
            wrap_cnt_d = wrap_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_cnt_q <= 16'd0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule
